// File: rtl/snowbro2_pkg.sv
// snowbro2_pkg
// Shared constants for the Snow Bros. 2 clock-enable generator.
//   - default accumulator width and NUM/DEN ratio for each enable rate
//     (all ratios are relative to the 48 MHz system clock)
//   - cen_params_ok(): elaboration-time legality test for one channel
package snowbro2_pkg;

  localparam int W_DEF         = 10;

  localparam int NUM675_DEF    = 9;
  localparam int DEN675_DEF    = 64;
  localparam int NUM1350_DEF   = 9;
  localparam int DEN1350_DEF   = 32;
  localparam int NUM4_DEF      = 1;
  localparam int DEN4_DEF      = 12;
  localparam int NUM3P375_DEF  = 9;
  localparam int DEN3P375_DEF  = 128;
  localparam int NUM1P6875_DEF = 9;
  localparam int DEN1P6875_DEF = 256;

  // A channel is legal when DEN is even (so HALF is exact), 0 < NUM <= HALF
  // (so CEN and CENB can never coincide) and the W+1-bit sum cannot wrap.
  function automatic bit cen_params_ok(input int num, input int den, input int w);
    longint span;
    span = longint'(64'd1 << w);
    return (den % 2 == 0) && (num > 0) && (num <= den / 2) &&
           (span > 2 * longint'(den));
  endfunction

endpackage

// File: rtl/snowbro2_frac_cen.sv
// snowbro2_frac_cen
// One fractional clock-enable channel: a phase accumulator that emits a
// one-cycle CEN every time it wraps past DEN, and a one-cycle CENB when it
// crosses DEN/2 (half a period later).  Average CEN rate is CLK*NUM/DEN.
// Ports:
//   CLK   in  system clock
//   RESET in  synchronous, active-high; clears accumulator and outputs
//   CEN   out main enable, registered, one cycle wide
//   CENB  out 180-degree offset enable, registered, one cycle wide
import snowbro2_pkg::*;

module snowbro2_frac_cen #(
  parameter int W   = W_DEF,
  parameter int NUM = NUM675_DEF,
  parameter int DEN = DEN675_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic CEN,
  output logic CENB
);

  if (!cen_params_ok(NUM, DEN, W)) begin : g_bad_params
    $fatal(1, "snowbro2_frac_cen: illegal NUM/DEN/W combination");
  end

  localparam logic [W:0] NUM_X  = (W+1)'(NUM);
  localparam logic [W:0] DEN_X  = (W+1)'(DEN);
  localparam logic [W:0] HALF_X = (W+1)'(DEN / 2);

  logic [W-1:0] acc_q, acc_d;
  logic         cen_q, cen_d;
  logic         cenb_q, cenb_d;
  logic [W:0]   nxt;

  always_comb begin
    nxt    = {1'b0, acc_q} + NUM_X;
    cen_d  = (nxt >= DEN_X);
    acc_d  = cen_d ? W'(nxt - DEN_X) : W'(nxt);
    // Half-phase crossing uses the pre-wrap sum, so it is taken before the
    // DEN subtraction; NUM <= HALF keeps it disjoint from cen_d.
    cenb_d = ({1'b0, acc_q} < HALF_X) && (nxt >= HALF_X);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q  <= '0;
      cen_q  <= 1'b0;
      cenb_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
    end
  end

  assign CEN  = cen_q;
  assign CENB = cenb_q;

endmodule

// File: rtl/snowbro2_cen_gen.sv
// snowbro2_cen_gen
// Clock-enable generator for the Snow Bros. 2 core.  Five fractional
// channels derived from the 48 MHz CLK.  The four NUM=9 channels have DENs
// that divide each other, so their pulses nest (1p6875 within 3p375 within
// 675 within 1350); CEN4 is independent.
// Ports:
//   CLK, RESET                 48 MHz clock, synchronous active-high reset
//   CEN675/CEN675B             6.75 MHz pixel enable (+ half phase)
//   CEN1350/CEN1350B           13.5 MHz 2x pixel enable (+ half phase)
//   CEN4/CEN4B                 4 MHz OKI enable (+ half phase)
//   CEN3p375/CEN3p375B         3.375 MHz YM2151 enable (+ half phase)
//   CEN1p6875/CEN1p6875B       1.6875 MHz YM2151 enable (+ half phase)
import snowbro2_pkg::*;

module snowbro2_cen_gen #(
  parameter int W         = W_DEF,
  parameter int NUM675    = NUM675_DEF,
  parameter int DEN675    = DEN675_DEF,
  parameter int NUM1350   = NUM1350_DEF,
  parameter int DEN1350   = DEN1350_DEF,
  parameter int NUM4      = NUM4_DEF,
  parameter int DEN4      = DEN4_DEF,
  parameter int NUM3p375  = NUM3P375_DEF,
  parameter int DEN3p375  = DEN3P375_DEF,
  parameter int NUM1p6875 = NUM1P6875_DEF,
  parameter int DEN1p6875 = DEN1P6875_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic CEN675,
  output logic CEN675B,
  output logic CEN1350,
  output logic CEN1350B,
  output logic CEN4,
  output logic CEN4B,
  output logic CEN3p375,
  output logic CEN3p375B,
  output logic CEN1p6875,
  output logic CEN1p6875B
);

  snowbro2_frac_cen #(.W(W), .NUM(NUM675), .DEN(DEN675)) u_cen675 (
    .CLK(CLK), .RESET(RESET), .CEN(CEN675), .CENB(CEN675B)
  );

  snowbro2_frac_cen #(.W(W), .NUM(NUM1350), .DEN(DEN1350)) u_cen1350 (
    .CLK(CLK), .RESET(RESET), .CEN(CEN1350), .CENB(CEN1350B)
  );

  snowbro2_frac_cen #(.W(W), .NUM(NUM4), .DEN(DEN4)) u_cen4 (
    .CLK(CLK), .RESET(RESET), .CEN(CEN4), .CENB(CEN4B)
  );

  snowbro2_frac_cen #(.W(W), .NUM(NUM3p375), .DEN(DEN3p375)) u_cen3p375 (
    .CLK(CLK), .RESET(RESET), .CEN(CEN3p375), .CENB(CEN3p375B)
  );

  snowbro2_frac_cen #(.W(W), .NUM(NUM1p6875), .DEN(DEN1p6875)) u_cen1p6875 (
    .CLK(CLK), .RESET(RESET), .CEN(CEN1p6875), .CENB(CEN1p6875B)
  );

endmodule

// File: tb/tb_snowbro2_cen_gen.sv
// tb_snowbro2_cen_gen
// Directed bench for snowbro2_cen_gen: first-pulse schedule after reset
// release, window counts, nesting/exclusion/gap invariants, mid-period
// reset, and a longer count run.
module tb_snowbro2_cen_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen675, cen675b, cen1350, cen1350b, cen4, cen4b;
  logic cen3p375, cen3p375b, cen1p6875, cen1p6875b;

  snowbro2_cen_gen dut (
    .CLK(clk), .RESET(rst),
    .CEN675(cen675), .CEN675B(cen675b),
    .CEN1350(cen1350), .CEN1350B(cen1350b),
    .CEN4(cen4), .CEN4B(cen4b),
    .CEN3p375(cen3p375), .CEN3p375B(cen3p375b),
    .CEN1p6875(cen1p6875), .CEN1p6875B(cen1p6875b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Output index: 0 675, 1 675B, 2 1350, 3 1350B, 4 4, 5 4B,
  //               6 3p375, 7 3p375B, 8 1p6875, 9 1p6875B
  int       edge_n;
  int       first_e [10];
  int       cnt     [10];
  logic [9:0] prev_o;
  int       last675, last4;
  int       nest_err, collide_err, consec_err, gap675_err, gap4_err, b4_err;
  int       gap675_seen, gap4_seen;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [9:0] outs();
    return {cen1p6875b, cen1p6875, cen3p375b, cen3p375, cen4b, cen4,
            cen1350b, cen1350, cen675b, cen675};
  endfunction

  task automatic clear_stats();
    edge_n = 0;
    for (int i = 0; i < 10; i++) begin
      first_e[i] = 0;
      cnt[i]     = 0;
    end
    prev_o  = '0;
    last675 = 0;
    last4   = 0;
  endtask

  // Advance one edge (reset held at its current value) and update stats.
  task automatic step();
    logic       was_rst;
    logic [9:0] o;
    @(posedge clk);
    was_rst = rst;
    #1;
    o = outs();
    if (!was_rst) begin
      edge_n++;
      for (int i = 0; i < 10; i++) begin
        if (o[i]) begin
          if (first_e[i] == 0) first_e[i] = edge_n;
          cnt[i]++;
          if (prev_o[i]) consec_err++;
        end
      end
      if (o[8] && !o[6]) nest_err++;
      if (o[6] && !o[0]) nest_err++;
      if (o[0] && !o[2]) nest_err++;
      if ((o[0] && o[1]) || (o[2] && o[3]) || (o[4] && o[5]) ||
          (o[6] && o[7]) || (o[8] && o[9])) collide_err++;
      if (o[0]) begin
        if (last675 != 0) begin
          gap675_seen++;
          if ((edge_n - last675 != 7) && (edge_n - last675 != 8)) gap675_err++;
        end
        last675 = edge_n;
      end
      if (o[4]) begin
        if (last4 != 0) begin
          gap4_seen++;
          if (edge_n - last4 != 12) gap4_err++;
        end
        last4 = edge_n;
      end
      if (o[5] && last4 != 0 && (edge_n - last4 != 6)) b4_err++;
    end
    prev_o = was_rst ? 10'd0 : o;
  endtask

  task automatic check_schedule(input string pfx);
    chk({pfx, "_first_675"},     first_e[0], 8);
    chk({pfx, "_first_675b"},    first_e[1], 4);
    chk({pfx, "_first_1350"},    first_e[2], 4);
    chk({pfx, "_first_1350b"},   first_e[3], 2);
    chk({pfx, "_first_4"},       first_e[4], 12);
    chk({pfx, "_first_4b"},      first_e[5], 6);
    chk({pfx, "_first_3p375"},   first_e[6], 15);
    chk({pfx, "_first_3p375b"},  first_e[7], 8);
    chk({pfx, "_first_1p6875"},  first_e[8], 29);
    chk({pfx, "_first_1p6875b"}, first_e[9], 15);
    chk({pfx, "_cnt_675"},     cnt[0], 36);
    chk({pfx, "_cnt_675b"},    cnt[1], 36);
    chk({pfx, "_cnt_1350"},    cnt[2], 72);
    chk({pfx, "_cnt_1350b"},   cnt[3], 72);
    chk({pfx, "_cnt_4"},       cnt[4], 21);
    chk({pfx, "_cnt_4b"},      cnt[5], 21);
    chk({pfx, "_cnt_3p375"},   cnt[6], 18);
    chk({pfx, "_cnt_3p375b"},  cnt[7], 18);
    chk({pfx, "_cnt_1p6875"},  cnt[8], 9);
    chk({pfx, "_cnt_1p6875b"}, cnt[9], 9);
  endtask

  initial begin
    nest_err = 0; collide_err = 0; consec_err = 0;
    gap675_err = 0; gap4_err = 0; b4_err = 0;
    gap675_seen = 0; gap4_seen = 0;
    clear_stats();

    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_outputs", outs(), 0);

    // Release and run the 256-cycle schedule window.
    rst = 1'b0;
    for (int i = 0; i < 256; i++) step();
    check_schedule("win1");

    // Continue to edge 1000, then a single-cycle mid-period reset.
    while (edge_n < 1000) step();
    chk("pre_reset_cnt_675", cnt[0], 140);
    rst = 1'b1;
    step();
    chk("midreset_outputs", outs(), 0);
    clear_stats();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) step();
    check_schedule("win2");

    // Long run from the second release.
    while (edge_n < 25600) step();
    chk("long_cnt_675",    cnt[0], 3600);
    chk("long_cnt_3p375",  cnt[6], 1800);
    chk("long_cnt_1350",   cnt[2], 7200);
    chk("long_cnt_4",      cnt[4], 2133);
    chk("long_cnt_1p6875", cnt[8], 900);

    chk("nesting_violations",   nest_err, 0);
    chk("cen_cenb_collisions",  collide_err, 0);
    chk("consecutive_highs",    consec_err, 0);
    chk("gap675_violations",    gap675_err, 0);
    chk("gap4_violations",      gap4_err, 0);
    chk("cen4b_offset_errors",  b4_err, 0);
    chk("gap675_observed",      gap675_seen > 3000, 1);
    chk("gap4_observed",        gap4_seen > 2000, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
